// File: rtl/adc_pkg.sv
// adc_pkg
//   Shared definitions for the ADC serial responder: frame geometry,
//   controller state encoding, sample-pattern encodings and the
//   per-channel sample generator.
package adc_pkg;

    localparam int NBITS      = 16;  // sclk falls per frame
    localparam int LEAD_ZEROS = 4;   // zero bits ahead of the sample
    localparam int DATA_BITS  = 12;  // sample width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        PAT_FIXED  = 2'd0,
        PAT_RAMP   = 2'd1,
        PAT_OFFSET = 2'd2,
        PAT_TOGGLE = 2'd3
    } pattern_e;

    // Sample for channel ch. The offset pattern adds 256*ch, i.e. ch
    // lands in bits [9:8]; the 12-bit sum wraps naturally.
    function automatic logic [DATA_BITS-1:0] sample_for(
        input logic [1:0]           sel,
        input logic [DATA_BITS-1:0] fixed_value,
        input logic [DATA_BITS-1:0] ramp,
        input logic                 toggle,
        input logic [1:0]           ch
    );
        logic [DATA_BITS-1:0] s;
        s = fixed_value;
        case (pattern_e'(sel))
            PAT_FIXED:  s = fixed_value;
            PAT_RAMP:   s = ramp;
            PAT_OFFSET: s = ramp + {2'b00, ch, 8'h00};
            PAT_TOGGLE: s = toggle ? 12'hFFF : 12'h000;
            default:    s = fixed_value;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge
//   Multi-flop synchronizer for one asynchronous input, followed by a
//   fall/rise detector on the synchronized level.
//   Ports:
//     clk, reset       system clock, async active-high reset
//     din              asynchronous input
//     level            synchronized level
//     fall, rise       one-clk edge pulses on the synchronized level
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic fall,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic [STAGES:0]   settle_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= {STAGES{RESET_VAL}};
            prev_q   <= RESET_VAL;
            settle_q <= '0;
        end else begin
            sync_q   <= {sync_q[STAGES-2:0], din};
            prev_q   <= sync_q[STAGES-1];
            settle_q <= {settle_q[STAGES-1:0], 1'b1};
        end
    end

    assign level = sync_q[STAGES-1];

    // After reset the chain flushes from RESET_VAL to the real input
    // level; that transition is not a real edge, so edges stay masked
    // until the chain and the history flop both hold real samples.
    assign fall = settle_q[STAGES] &  prev_q & ~level;
    assign rise = settle_q[STAGES] & ~prev_q &  level;

endmodule

// File: rtl/adc_serial_responder.sv
// adc_serial_responder
//   Emulates three serial ADCs answering a pixel reader. Each cs-low
//   frame shifts out {4'b0, sample} MSB first on sdo[k], one bit per
//   sclk fall.
//   Ports:
//     clk, reset     system clock, async active-high reset
//     cs, sclk       reader chip select (active low) and serial clock
//     enable         frames are answered only when high at cs fall
//     pattern_sel    0 fixed, 1 ramp, 2 channel-offset ramp, 3 toggle
//     fixed_value    sample for pattern 0
//     sdo            serial data, one bit per channel
//     frame_done     one-clk pulse when a frame completes
//     frame_count    completed frames, wrapping
//
//   state | meaning
//   IDLE  | waiting for cs fall with enable high; sdo low
//   LOAD  | latch shift words for all channels
//   SHIFT | present MSB, shift on each sclk fall
//   DONE  | frame complete; sdo low until cs rises
module adc_serial_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int NBITS       = adc_pkg::NBITS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        sclk,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [11:0] fixed_value,
    output logic [2:0]  sdo,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    localparam logic [4:0] LAST_EDGE = 5'(NBITS - 1);
    localparam logic [4:0] FULL_CNT  = 5'(NBITS);

    adc_pkg::state_e state, state_nx;

    logic cs_lvl, cs_fall, cs_rise;
    logic sclk_lvl, sclk_fall, sclk_rise;

    logic [4:0]        bit_cnt;
    logic [11:0]       ramp;
    logic [2:0][15:0]  shreg;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .din   (cs),
        .level (cs_lvl),
        .fall  (cs_fall),
        .rise  (cs_rise)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sclk),
        .level (sclk_lvl),
        .fall  (sclk_fall),
        .rise  (sclk_rise)
    );

    logic unused_edges;
    assign unused_edges = ^{cs_lvl, sclk_lvl, sclk_rise};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= adc_pkg::ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        sdo      = 3'b000;
        case (state)
            adc_pkg::ST_IDLE: begin
                if (cs_fall && enable) state_nx = adc_pkg::ST_LOAD;
            end
            adc_pkg::ST_LOAD: begin
                state_nx = cs_rise ? adc_pkg::ST_IDLE : adc_pkg::ST_SHIFT;
            end
            adc_pkg::ST_SHIFT: begin
                sdo = {shreg[2][15], shreg[1][15], shreg[0][15]};
                if (cs_rise)
                    state_nx = adc_pkg::ST_IDLE;
                else if (sclk_fall && bit_cnt == LAST_EDGE)
                    state_nx = adc_pkg::ST_DONE;
            end
            adc_pkg::ST_DONE: begin
                if (cs_rise) state_nx = adc_pkg::ST_IDLE;
            end
            default: state_nx = adc_pkg::ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt     <= '0;
            ramp        <= '0;
            frame_count <= '0;
            frame_done  <= 1'b0;
            shreg       <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                adc_pkg::ST_IDLE: bit_cnt <= '0;
                adc_pkg::ST_LOAD: begin
                    bit_cnt <= '0;
                    for (int k = 0; k < 3; k++)
                        shreg[k] <= {{adc_pkg::LEAD_ZEROS{1'b0}},
                                     adc_pkg::sample_for(pattern_sel, fixed_value, ramp,
                                                         frame_count[0], 2'(k))};
                end
                adc_pkg::ST_SHIFT: begin
                    if (sclk_fall && !cs_rise) begin
                        for (int k = 0; k < 3; k++)
                            shreg[k] <= {shreg[k][14:0], 1'b0};
                        if (bit_cnt != FULL_CNT) bit_cnt <= bit_cnt + 5'd1;
                    end
                    if (state_nx == adc_pkg::ST_DONE) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        ramp        <= ramp + 12'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
